vga_rx_timing_decoder: RTL and testbench

//  Receive-side counterpart of the VGA timing generator: consumes Hsynq/Vsynq/RGB in the
//  clk_25MHz domain and recovers pixel coordinates, data-enable and registered pixel data.

---
 rtl/vga_rx_timing_decoder.sv | 148 ++++++++++++++
 tb/tb_vga_rx_timing_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_rx_timing_decoder.sv
// vga_rx_timing_decoder: recovers pixel coordinates, data-enable and pixel data from a VGA
// sync/RGB stream, measures line/frame totals, flags timing errors and reports lock.
// Optional macro VGA_RX_FRAME_CHECKSUM_EN adds a per-frame 16-bit sum of active pixels.
module vga_rx_timing_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_ACT_START = 144,
    parameter int H_ACT_END   = 784,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_END   = 515,
    parameter bit SYNC_ACTIVE = 1'b1,
    parameter int LOCK_COUNT  = 2
) (
    input  logic        clk_25MHz,
    input  logic        rst,
    input  logic        Hsynq,
    input  logic        Vsynq,
    input  logic [3:0]  Red,
    input  logic [3:0]  Green,
    input  logic [3:0]  Blue,
    output logic [15:0] pix_x,
    output logic [15:0] pix_y,
    output logic        de,
    output logic [11:0] pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic        timing_err,
    output logic [15:0] h_total_meas,
    output logic [15:0] v_total_meas,
    output logic [15:0] frame_checksum
);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam logic [GW-1:0] LC = GW'(LOCK_COUNT);
    localparam logic [15:0] HT = 16'(H_TOTAL);
    localparam logic [15:0] VT = 16'(V_TOTAL);
    localparam logic [15:0] HS = 16'(H_ACT_START);
    localparam logic [15:0] HE = 16'(H_ACT_END);
    localparam logic [15:0] VS = 16'(V_ACT_START);
    localparam logic [15:0] VE = 16'(V_ACT_END);
    localparam logic [15:0] TO_LAST = 16'(2 * H_TOTAL - 1);

    logic hs_r, vs_r, hs_d, vs_d;
    logic [11:0] rgb_r, rgb_n;
    logic [15:0] h_cnt, v_cnt, h_inc, v_inc, h_pos, v_pos;
    logic h_seen, v_seen, timed_out, timed_out_n;
    logic [GW-1:0] h_good, v_good, h_good_n, v_good_n;
    logic rise_h, rise_v, h_meas, v_meas, h_bad, v_bad, timeout, de_n;

    // Position, measurement and lock decisions for the current stage-1 sample
    always_comb begin
        rise_h      = hs_r && !hs_d;
        rise_v      = vs_r && !vs_d;
        h_inc       = (h_cnt == 16'hFFFF) ? h_cnt : h_cnt + 16'd1;
        v_inc       = (v_cnt == 16'hFFFF) ? v_cnt : v_cnt + 16'd1;
        h_pos       = rise_h ? '0 : h_inc;
        v_pos       = rise_h ? (rise_v ? '0 : v_inc) : v_cnt;
        h_meas      = rise_h && h_seen;
        v_meas      = rise_v && v_seen;
        h_bad       = h_meas && h_inc != HT;
        v_bad       = v_meas && (!rise_h || v_inc != VT);
        timeout     = !rise_h && h_cnt == TO_LAST;
        timed_out_n = !rise_h && (timed_out || timeout);
        h_good_n    = (h_bad || timeout) ? '0 : (h_meas && h_good != LC) ? h_good + GW'(1) : h_good;
        v_good_n    = (v_bad || timeout) ? '0 : (v_meas && v_good != LC) ? v_good + GW'(1) : v_good;
        de_n        = (v_seen || rise_v) && !timed_out_n && h_pos >= HS && h_pos < HE
                      && v_pos >= VS && v_pos < VE;
        rgb_n       = de_n ? rgb_r : '0;
    end

    // Stage 1: capture inputs, normalise sync polarity, keep previous sync for edge detection
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            {hs_r, vs_r, hs_d, vs_d} <= '0;
            rgb_r <= '0;
        end else begin
            hs_r  <= Hsynq == SYNC_ACTIVE;
            vs_r  <= Vsynq == SYNC_ACTIVE;
            hs_d  <= hs_r;
            vs_d  <= vs_r;
            rgb_r <= {Red, Green, Blue};
        end
    end

    // Counters, first-edge flags, timeout latch and good-measurement history
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            h_seen    <= 1'b0;
            v_seen    <= 1'b0;
            timed_out <= 1'b0;
            h_good    <= '0;
            v_good    <= '0;
        end else begin
            h_cnt     <= h_pos;
            v_cnt     <= v_pos;
            h_seen    <= h_seen || rise_h;
            v_seen    <= v_seen || rise_v;
            timed_out <= timed_out_n;
            h_good    <= h_good_n;
            v_good    <= v_good_n;
        end
    end

    // Stage 2: register every output so input-to-output latency is two clocks
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            pix_x        <= '0;
            pix_y        <= '0;
            de           <= 1'b0;
            pix_rgb      <= '0;
            frame_start  <= 1'b0;
            locked       <= 1'b0;
            timing_err   <= 1'b0;
            h_total_meas <= '0;
            v_total_meas <= '0;
        end else begin
            pix_x        <= de_n ? h_pos - HS : '0;
            pix_y        <= de_n ? v_pos - VS : '0;
            de           <= de_n;
            pix_rgb      <= rgb_n;
            frame_start  <= rise_v;
            locked       <= h_good_n == LC && v_good_n == LC;
            timing_err   <= h_bad || v_bad || timeout;
            h_total_meas <= h_meas ? h_inc : h_total_meas;
            v_total_meas <= v_meas ? v_inc : v_total_meas;
        end
    end

`ifdef VGA_RX_FRAME_CHECKSUM_EN
    logic [15:0] cks_acc;

    // Sum active pixels; publish and restart on each Vsynq leading edge
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            cks_acc        <= '0;
            frame_checksum <= '0;
        end else if (rise_v) begin
            cks_acc        <= '0;
            frame_checksum <= cks_acc;
        end else begin
            cks_acc        <= cks_acc + {4'd0, rgb_n};
        end
    end
`else
    assign frame_checksum = '0;
`endif
endmodule

// File: tb/tb_vga_rx_timing_decoder.sv
// tb_vga_rx_timing_decoder: directed checks of the VGA receive decoder using a scaled-down
// 50x30 timing (32x22 active) so whole frames fit in a short run.
module tb_vga_rx_timing_decoder;
    localparam int HT = 50, VT = 30, HS = 10, HE = 42, VS = 4, VE = 26, HSW = 4, VSW = 2;
    localparam int LIMIT = 4 * HT * VT;

    logic clk_25MHz = 1'b0, rst = 1'b1, Hsynq = 1'b0, Vsynq = 1'b0;
    logic [3:0] Red = '0, Green = '0, Blue = '0;
    logic [15:0] pix_x, pix_y, h_total_meas, v_total_meas, frame_checksum;
    logic [11:0] pix_rgb;
    logic de, frame_start, locked, timing_err;

    int total = 0, bad = 0, err_pulses = 0;
    int gx = 0, gy = 0, short_y = -1;
    bit mute = 1'b0, white = 1'b0, running = 1'b0;
    int hx[3] = '{-1, -1, -1};
    int hy[3] = '{-1, -1, -1};

    typedef struct {
        int x;
        int y;
        bit de;
        int px;
        int py;
    } vec_t;
    vec_t vecs[10];

    vga_rx_timing_decoder #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(HS), .H_ACT_END(HE),
        .V_ACT_START(VS), .V_ACT_END(VE), .SYNC_ACTIVE(1'b1), .LOCK_COUNT(2)
    ) dut (
        .clk_25MHz(clk_25MHz), .rst(rst), .Hsynq(Hsynq), .Vsynq(Vsynq),
        .Red(Red), .Green(Green), .Blue(Blue),
        .pix_x(pix_x), .pix_y(pix_y), .de(de), .pix_rgb(pix_rgb),
        .frame_start(frame_start), .locked(locked), .timing_err(timing_err),
        .h_total_meas(h_total_meas), .v_total_meas(v_total_meas),
        .frame_checksum(frame_checksum)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    function automatic logic [11:0] pat(input int x, input int y);
        return {x[3:0], y[3:0], x[7:4]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (gen pos %0d,%0d)", name, act, exp, hx[2], hy[2]);
        end
    endtask

    // One generator clock; afterwards DUT outputs belong to coordinates hx[2],hy[2]
    task automatic gen_cycle();
        @(negedge clk_25MHz);
        if (timing_err) err_pulses++;
        hx[2] = hx[1]; hy[2] = hy[1];
        hx[1] = hx[0]; hy[1] = hy[0];
        if (running) begin
            Hsynq = gx < HSW && !(mute && (gy == 5 || gy == 6));
            Vsynq = gy < VSW;
            {Red, Green, Blue} = white ? 12'hFFF : pat(gx, gy);
            hx[0] = gx; hy[0] = gy;
            if (gx >= ((gy == short_y) ? HT - 1 : HT) - 1) begin
                gx = 0;
                gy = (gy == VT - 1) ? 0 : gy + 1;
            end else begin
                gx++;
            end
        end else begin
            Hsynq = 1'b0; Vsynq = 1'b0;
            {Red, Green, Blue} = '0;
            hx[0] = -1; hy[0] = -1;
        end
    endtask

    task automatic run_to(input int x, input int y);
        int n = 0;
        bit hit = 1'b0;
        do begin
            gen_cycle();
            n++;
            hit = hx[2] == x && hy[2] == y;
        end while (!hit && n < LIMIT);
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL run_to: position %0d,%0d not reached in %0d cycles", x, y, n);
        end
    endtask

    task automatic chk_zero();
        chk("zero pix_x", 32'(pix_x), 0);
        chk("zero pix_y", 32'(pix_y), 0);
        chk("zero de", 32'(de), 0);
        chk("zero pix_rgb", 32'(pix_rgb), 0);
        chk("zero frame_start", 32'(frame_start), 0);
        chk("zero locked", 32'(locked), 0);
        chk("zero timing_err", 32'(timing_err), 0);
        chk("zero h_total_meas", 32'(h_total_meas), 0);
        chk("zero v_total_meas", 32'(v_total_meas), 0);
        chk("zero frame_checksum", 32'(frame_checksum), 0);
    endtask

    initial begin
        int e0, e1;
        logic [15:0] exp_cks;
        vecs[0] = '{x: 10, y: 3,  de: 1'b0, px: 0,  py: 0};
        vecs[1] = '{x: 9,  y: 4,  de: 1'b0, px: 0,  py: 0};
        vecs[2] = '{x: 10, y: 4,  de: 1'b1, px: 0,  py: 0};
        vecs[3] = '{x: 11, y: 4,  de: 1'b1, px: 1,  py: 0};
        vecs[4] = '{x: 41, y: 4,  de: 1'b1, px: 31, py: 0};
        vecs[5] = '{x: 42, y: 4,  de: 1'b0, px: 0,  py: 0};
        vecs[6] = '{x: 20, y: 10, de: 1'b1, px: 10, py: 6};
        vecs[7] = '{x: 41, y: 25, de: 1'b1, px: 31, py: 21};
        vecs[8] = '{x: 42, y: 25, de: 1'b0, px: 0,  py: 0};
        vecs[9] = '{x: 10, y: 26, de: 1'b0, px: 0,  py: 0};
`ifdef VGA_RX_FRAME_CHECKSUM_EN
        exp_cks = 16'((HE - HS) * (VE - VS) * 4095);
`else
        exp_cks = 16'd0;
`endif
        // Power-up reset
        repeat (4) gen_cycle();
        chk_zero();
        rst = 1'b0;
        running = 1'b1;
        // Lock acquisition over three frames
        e0 = err_pulses;
        run_to(0, 0);
        chk("f1 frame_start", 32'(frame_start), 1);
        chk("f1 locked", 32'(locked), 0);
        run_to(0, 0);
        chk("f2 h_total_meas", 32'(h_total_meas), HT);
        chk("f2 v_total_meas", 32'(v_total_meas), VT);
        chk("f2 locked", 32'(locked), 0);
        run_to(HT - 1, VT - 1);
        chk("pre-lock locked", 32'(locked), 0);
        gen_cycle();
        chk("f3 frame_start", 32'(frame_start), 1);
        chk("f3 locked", 32'(locked), 1);
        chk("lock err pulses", 32'(err_pulses - e0), 0);
        // Active-window boundaries on a locked stream
        for (int i = 0; i < 10; i++) begin
            run_to(vecs[i].x, vecs[i].y);
            chk("vec de", 32'(de), 32'(vecs[i].de));
            chk("vec pix_x", 32'(pix_x), 32'(vecs[i].px));
            chk("vec pix_y", 32'(pix_y), 32'(vecs[i].py));
            if (vecs[i].de) chk("vec pix_rgb", 32'(pix_rgb), 32'(pat(vecs[i].x, vecs[i].y)));
        end
        run_to(VE - 1 < 0 ? 0 : 0, 0);
        // All-white frame checksum
        white = 1'b1;
        run_to(0, 0);
        white = 1'b0;
        chk("white frame_checksum", 32'(frame_checksum), 32'(exp_cks));
        // One short line
        short_y = 10;
        e0 = err_pulses;
        run_to(0, 11);
        chk("short timing_err", 32'(timing_err), 1);
        chk("short h_total_meas", 32'(h_total_meas), HT - 1);
        chk("short locked", 32'(locked), 0);
        gen_cycle();
        chk("short err one cycle", 32'(timing_err), 0);
        short_y = -1;
        run_to(0, 12);
        chk("short +1 line locked", 32'(locked), 0);
        chk("short +1 line h_total_meas", 32'(h_total_meas), HT);
        chk("short err pulses", 32'(err_pulses - e0), 1);
        run_to(0, 0);
        chk("short relocked", 32'(locked), 1);
        // Hsynq missing for two lines
        mute = 1'b1;
        e0 = err_pulses;
        run_to(0, 5);
        e1 = err_pulses;
        chk("mute no early err", 32'(e1 - e0), 0);
        run_to(20, 6);
        chk("timeout de", 32'(de), 0);
        chk("timeout locked", 32'(locked), 0);
        run_to(HT - 1, 6);
        chk("timeout err pulses", 32'(err_pulses - e1), 1);
        mute = 1'b0;
        run_to(20, 7);
        chk("resume de", 32'(de), 1);
        chk("resume pix_x", 32'(pix_x), 10);
        chk("resume pix_y", 32'(pix_y), 1);
        run_to(0, 0);
        chk("short frame v_total_meas", 32'(v_total_meas), VT - 2);
        chk("short frame timing_err", 32'(timing_err), 1);
        chk("short frame locked", 32'(locked), 0);
        run_to(0, 0);
        chk("recover f1 locked", 32'(locked), 0);
        chk("recover f1 v_total_meas", 32'(v_total_meas), VT);
        run_to(0, 0);
        chk("recover f2 locked", 32'(locked), 1);
        // Mid-frame reset
        run_to(20, 12);
        rst = 1'b1;
        gen_cycle();
        chk_zero();
        rst = 1'b0;
        e0 = err_pulses;
        run_to(0, 0);
        chk("post-rst f1 frame_start", 32'(frame_start), 1);
        chk("post-rst f1 locked", 32'(locked), 0);
        run_to(0, 0);
        chk("post-rst f2 locked", 32'(locked), 0);
        chk("post-rst f2 v_total_meas", 32'(v_total_meas), VT);
        run_to(0, 0);
        chk("post-rst f3 locked", 32'(locked), 1);
        chk("post-rst err pulses", 32'(err_pulses - e0), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
